// File: rtl/fir_scan_capture_if.sv
// rtl/fir_scan_capture_if.sv - ready/valid word readout from the FIR scan capture
interface fir_scan_capture_if #(
    parameter int M = 8
);
    logic         word_valid;
    logic         word_ready;
    logic [M-1:0] word_tap;
    logic [15:0]  word_x;
    logic [25:0]  word_w;

    modport master (output word_valid, word_tap, word_x, word_w, input word_ready);
    modport slave  (input word_valid, word_tap, word_x, word_w, output word_ready);
endinterface

// File: rtl/fir_scan_capture.sv
// rtl/fir_scan_capture.sv - scan master and deserializer for the FIR tap scan chain
module fir_scan_capture #(
    parameter int TAPS       = 256,
    parameter int M          = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_fir_act,
    output logic o_scan_en,
    input  logic i_scan_in_x,
    input  logic i_scan_in_w,
    output logic o_busy,
    output logic o_done,
    output logic o_sext_err,
    fir_scan_capture_if.master word
);
    localparam int           AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int           FW       = M + 16 + 26;
    localparam logic [M-1:0] LAST_TAP = M'(TAPS - 1);
    localparam logic [M:0]   TAPS_W   = (M + 1)'(TAPS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_FIR, S_SHIFT, S_PAUSE, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_scan_en, w_scan_en_nxt, w_start_frame;
    logic [4:0]      r_ecnt;
    logic [M:0]      r_issued, r_pushed;
    logic            r_sample_en;
    logic [4:0]      r_bcnt;
    logic [25:0]     r_sr_x, r_sr_w;
    logic            r_sext_err;
    logic [FW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;

    logic [25:0]     w_sr_x_nxt, w_sr_w_nxt;
    logic            w_push, w_pop, w_bp, w_boundary, w_more, w_last_push;
    logic [M-1:0]    w_tap;
    logic [FW-1:0]   w_head;
    int              w_occ;

    assign w_sr_x_nxt  = {i_scan_in_x, r_sr_x[25:1]};
    assign w_sr_w_nxt  = {i_scan_in_w, r_sr_w[25:1]};
    assign w_push      = r_sample_en && (r_bcnt == 5'd25);
    assign w_pop       = (r_count != '0) && word.word_ready;
    assign w_tap       = LAST_TAP - r_pushed[M-1:0];
    // Frames already issued but not yet pushed still need a FIFO slot.
    assign w_occ       = int'(r_count) + int'(r_issued) - int'(r_pushed);
    assign w_bp        = w_occ >= FIFO_DEPTH;
    assign w_boundary  = !r_scan_en || (r_ecnt == 5'd25);
    assign w_more      = r_issued != TAPS_W;
    assign w_last_push = w_push && (r_pushed == TAPS_W - 1'b1);

    always_comb begin
        w_state_nxt   = r_state;
        w_start_frame = 1'b0;
        case (r_state)
            S_IDLE:     if (i_start) w_state_nxt = S_WAIT_FIR;
            S_WAIT_FIR: if (!i_fir_act) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_last_push) begin
                    w_state_nxt = S_DONE;
                end else if (w_boundary && w_more) begin
                    if (w_bp) w_state_nxt = S_PAUSE;
                    else      w_start_frame = 1'b1;
                end
            end
            S_PAUSE: begin
                if (!w_bp) begin
                    w_state_nxt   = S_SHIFT;
                    w_start_frame = 1'b1;
                end
            end
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        // A frame, once started, always runs its full 26 cycles.
        w_scan_en_nxt = (r_scan_en && (r_ecnt != 5'd25)) || w_start_frame;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_scan_en   <= 1'b0;
            r_ecnt      <= '0;
            r_issued    <= '0;
            r_pushed    <= '0;
            r_sample_en <= 1'b0;
            r_bcnt      <= '0;
            r_sr_x      <= '0;
            r_sr_w      <= '0;
            r_sext_err  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_scan_en   <= w_scan_en_nxt;
            r_sample_en <= r_scan_en;
            if (r_scan_en) r_ecnt <= (r_ecnt == 5'd25) ? 5'd0 : r_ecnt + 5'd1;
            if (w_start_frame) r_issued <= r_issued + 1'b1;
            if (w_push) r_pushed <= r_pushed + 1'b1;
            if (r_sample_en) begin
                r_sr_x <= w_sr_x_nxt;
                r_sr_w <= w_sr_w_nxt;
                r_bcnt <= (r_bcnt == 5'd25) ? 5'd0 : r_bcnt + 5'd1;
            end
            if (w_push && (w_sr_x_nxt[25:16] != {10{w_sr_x_nxt[15]}})) r_sext_err <= 1'b1;
            if ((r_state == S_IDLE) && i_start) begin
                r_issued   <= '0;
                r_pushed   <= '0;
                r_sext_err <= 1'b0;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_tap, w_sr_x_nxt[15:0], w_sr_w_nxt};
    end

    assign w_head          = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign word.word_valid = r_count != '0;
    assign word.word_tap   = w_head[FW-1 -: M];
    assign word.word_x     = w_head[41:26];
    assign word.word_w     = w_head[25:0];

    assign o_scan_en  = r_scan_en;
    assign o_busy     = (r_state == S_WAIT_FIR) || (r_state == S_SHIFT) || (r_state == S_PAUSE);
    assign o_done     = r_state == S_DONE;
    assign o_sext_err = r_sext_err;
endmodule
